// File: rtl/quad_pkg.sv
// Shared types and the phase-change classifier for the mod-4 phase decoder.
package quad_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ERR
    } move_t;

    // A two-bit subtract wraps modulo 4, so delta 2 is the only ambiguous jump.
    function automatic move_t classify(input logic [PHASE_W-1:0] prev,
                                       input logic [PHASE_W-1:0] cur);
        logic [PHASE_W-1:0] delta;
        move_t              move;
        delta = cur - prev;
        move  = MOVE_NONE;
        case (delta)
            2'd1:    move = MOVE_UP;
            2'd2:    move = MOVE_ERR;
            2'd3:    move = MOVE_DOWN;
            default: move = MOVE_NONE;
        endcase
        return move;
    endfunction

endpackage

// File: rtl/phase_sync.sv
// Multi-stage synchronizer for the asynchronous 2-bit phase, with a flag that
// marks when the last stage holds a genuinely sampled value after reset.
module phase_sync
    import quad_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic [PHASE_W-1:0] phase_in,
    output logic [PHASE_W-1:0] phase_s,
    output logic               valid
);

    logic [PHASE_W-1:0] stage [STAGES];
    logic [STAGES-1:0]  filled;

    // The fill flags travel alongside the data so the decoder never locks onto reset zeros.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
            filled <= '0;
        end else begin
            stage[0] <= phase_in;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            filled <= {filled[STAGES-2:0], 1'b1};
        end
    end

    assign phase_s = stage[STAGES-1];
    assign valid   = filled[STAGES-1];

endmodule

// File: rtl/quad_phase_decoder.sv
// Receive side of the mod-4 phase interface: synchronizes the phase, classifies
// each change and keeps a wrapping position plus a saturating error count.
module quad_phase_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NBITS_POS   = 8,
    parameter int NBITS_ERR   = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PHASE_W-1:0]   phase_in,
    input  logic                 load,
    input  logic [NBITS_POS-1:0] load_value,
    output logic [NBITS_POS-1:0] position,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 dir,
    output logic                 err,
    output logic [NBITS_ERR-1:0] err_count,
    output logic                 locked
);

    logic [PHASE_W-1:0] phase_s;
    logic               sync_valid;
    logic [PHASE_W-1:0] prev_phase;
    move_t              move;

    phase_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_2   (clk_2),
        .reset   (reset),
        .phase_in(phase_in),
        .phase_s (phase_s),
        .valid   (sync_valid)
    );

    assign move = classify(prev_phase, phase_s);

    // prev_phase tracks every cycle so a disabled stretch never turns into a step on re-enable.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            prev_phase <= '0;
            position   <= '0;
            err_count  <= '0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            err        <= 1'b0;
            dir        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            prev_phase <= phase_s;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            err        <= 1'b0;
            if (!locked) begin
                locked <= sync_valid;
            end else if (enable) begin
                case (move)
                    MOVE_UP: begin
                        position <= position + 1'b1;
                        step_up  <= 1'b1;
                        dir      <= 1'b1;
                    end
                    MOVE_DOWN: begin
                        position  <= position - 1'b1;
                        step_down <= 1'b1;
                        dir       <= 1'b0;
                    end
                    MOVE_ERR: begin
                        err <= 1'b1;
                        if (err_count != {NBITS_ERR{1'b1}}) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Load overrides any step taken in the same cycle; the pulses still report the move.
            if (load) begin
                position <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_quad_phase_decoder.sv
// Scoreboard bench for quad_phase_decoder: a cycle reference model queues expected
// outputs at each rising edge and they are compared on the following falling edge.
module tb_quad_phase_decoder;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] phase_in;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] position;
    logic       step_up;
    logic       step_down;
    logic       dir;
    logic       err;
    logic [3:0] err_count;
    logic       locked;

    int errors   = 0;
    int n_checks = 0;
    int up_cnt   = 0;
    int down_cnt = 0;
    int err_cnt  = 0;

    typedef struct packed {
        logic [7:0] pos;
        logic       up;
        logic       down;
        logic       dir;
        logic       err;
        logic [3:0] errc;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] m_pv [2];
    bit         m_vv [2];
    logic [1:0] m_prev;
    bit         m_locked;
    logic [7:0] m_pos;
    logic [3:0] m_errc;
    bit         m_dir;

    quad_phase_decoder #(
        .SYNC_STAGES(2),
        .NBITS_POS  (8),
        .NBITS_ERR  (4)
    ) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .enable    (enable),
        .phase_in  (phase_in),
        .load      (load),
        .load_value(load_value),
        .position  (position),
        .step_up   (step_up),
        .step_down (step_down),
        .dir       (dir),
        .err       (err),
        .err_count (err_count),
        .locked    (locked)
    );

    always #5 clk_2 = ~clk_2;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ph, input int cycles);
        phase_in = ph;
        repeat (cycles) @(negedge clk_2);
    endtask

    // Reference model: two-sample delay line, then modulo-4 difference against the previous sample.
    always @(posedge clk_2) begin
        exp_t       e;
        logic [1:0] cur;
        bit         cur_ok;
        bit         up, down, er;
        int         d;
        up = 0;
        down = 0;
        er = 0;
        if (reset) begin
            m_pv[0] = 2'd0; m_pv[1] = 2'd0;
            m_vv[0] = 0;    m_vv[1] = 0;
            m_prev = 2'd0; m_locked = 0; m_pos = 8'd0; m_errc = 4'd0; m_dir = 0;
        end else begin
            cur    = m_pv[1];
            cur_ok = m_vv[1];
            if (!m_locked) begin
                m_locked = cur_ok;
            end else if (enable) begin
                d = (int'(cur) - int'(m_prev) + 4) % 4;
                if (d == 1) begin
                    m_pos = m_pos + 8'd1; up = 1; m_dir = 1;
                end else if (d == 3) begin
                    m_pos = m_pos - 8'd1; down = 1; m_dir = 0;
                end else if (d == 2) begin
                    er = 1;
                    if (m_errc < 4'd15) m_errc = m_errc + 4'd1;
                end
            end
            if (load) m_pos = load_value;
            m_prev  = cur;
            m_pv[1] = m_pv[0]; m_vv[1] = m_vv[0];
            m_pv[0] = phase_in; m_vv[0] = 1;
        end
        e.pos = m_pos; e.up = up; e.down = down; e.dir = m_dir;
        e.err = er; e.errc = m_errc; e.locked = m_locked;
        exp_q.push_back(e);
    end

    always @(negedge clk_2) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_position", position, e.pos);
            checkOutput("sb_step_up", step_up, e.up);
            checkOutput("sb_step_down", step_down, e.down);
            checkOutput("sb_dir", dir, e.dir);
            checkOutput("sb_err", err, e.err);
            checkOutput("sb_err_count", err_count, e.errc);
            checkOutput("sb_locked", locked, e.locked);
        end
    end

    always @(posedge clk_2) begin
        #1;
        if (step_up === 1'b1) up_cnt++;
        if (step_down === 1'b1) down_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        reset = 1'b1; enable = 1'b0; phase_in = 2'd2; load = 1'b0; load_value = 8'd0;
        repeat (5) @(negedge clk_2);
        checkOutput("rst_position", position, 8'd0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_err_count", err_count, 4'd0);
        checkOutput("rst_pulses", {step_up, step_down, err, dir}, 4'd0);

        reset = 1'b0;
        up_cnt = 0; down_cnt = 0; err_cnt = 0;
        repeat (2) @(negedge clk_2);
        checkOutput("lock_early", locked, 1'b0);
        @(negedge clk_2);
        checkOutput("lock_acquired", locked, 1'b1);
        checkOutput("lock_position", position, 8'd0);
        checkOutput("lock_no_pulse", up_cnt + down_cnt + err_cnt, 0);

        // Park on phase 0 while disabled, then count up through a full revolution.
        applyStimulus(2'd0, 4);
        enable = 1'b1;
        up_cnt = 0;
        applyStimulus(2'd1, 4);
        applyStimulus(2'd2, 4);
        applyStimulus(2'd3, 4);
        applyStimulus(2'd0, 4);
        checkOutput("up_pulses", up_cnt, 4);
        checkOutput("up_position", position, 8'd4);
        checkOutput("up_dir", dir, 1'b1);

        load = 1'b1; load_value = 8'd0;
        @(negedge clk_2);
        load = 1'b0;
        down_cnt = 0;
        applyStimulus(2'd3, 4);
        applyStimulus(2'd2, 4);
        checkOutput("down_pulses", down_cnt, 2);
        checkOutput("down_position", position, 8'hFE);
        checkOutput("down_dir", dir, 1'b0);

        load = 1'b1; load_value = 8'hFF;
        @(negedge clk_2);
        load = 1'b0;
        applyStimulus(2'd3, 4);
        checkOutput("wrap_position", position, 8'h00);
        checkOutput("wrap_dir", dir, 1'b1);

        applyStimulus(2'd0, 4);
        err_cnt = 0;
        applyStimulus(2'd2, 4);
        checkOutput("err_first_count", err_count, 4'd1);
        checkOutput("err_position", position, 8'd1);
        for (int i = 0; i < 17; i++) begin
            applyStimulus((i % 2 == 0) ? 2'd0 : 2'd2, 3);
        end
        checkOutput("err_pulses", err_cnt, 18);
        checkOutput("err_saturated", err_count, 4'hF);
        checkOutput("err_hold_position", position, 8'd1);

        // Load lands on the same edge the up step is classified.
        up_cnt = 0;
        phase_in = 2'd1;
        repeat (2) @(negedge clk_2);
        load = 1'b1; load_value = 8'h5A;
        @(negedge clk_2);
        checkOutput("load_position", position, 8'h5A);
        checkOutput("load_step_up", step_up, 1'b1);
        load = 1'b0;
        repeat (3) @(negedge clk_2);
        checkOutput("load_held", position, 8'h5A);

        enable = 1'b0;
        up_cnt = 0; down_cnt = 0; err_cnt = 0;
        applyStimulus(2'd2, 4);
        applyStimulus(2'd3, 4);
        enable = 1'b1;
        repeat (6) @(negedge clk_2);
        checkOutput("disable_pulses", up_cnt + down_cnt + err_cnt, 0);
        checkOutput("disable_position", position, 8'h5A);

        applyStimulus(2'd0, 1);
        applyStimulus(2'd1, 1);
        reset = 1'b1;
        applyStimulus(2'd2, 1);
        checkOutput("midrst_position", position, 8'd0);
        checkOutput("midrst_locked", locked, 1'b0);
        checkOutput("midrst_err_count", err_count, 4'd0);
        checkOutput("midrst_pulses", {step_up, step_down, err, dir}, 4'd0);
        applyStimulus(2'd3, 1);
        reset = 1'b0;
        up_cnt = 0; down_cnt = 0; err_cnt = 0;
        repeat (8) @(negedge clk_2);
        checkOutput("relock_pulses", up_cnt + down_cnt + err_cnt, 0);
        checkOutput("relock_locked", locked, 1'b1);
        checkOutput("relock_position", position, 8'd0);

        repeat (2) @(negedge clk_2);
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
